opimm_sequencer: RTL and testbench
==================================

# opimm_sequencer

Multi-cycle control FSM that fetches OP-IMM instructions, reads the register file, and sequences the shared combinational ALU. It writes results back to the register file and advances the PC. It sits between instruction memory, the register file, and the ALU in the single-issue core. It stops in a trap state on any instruction the ALU cannot execute.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk  in  1  core clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; forces IDLE and reset values immediately
- imem_req  out  1  fetch request; high throughout FETCH
- imem_addr  out  32  fetch address, equal to pc
- imem_rdata  in  32  instruction word; sampled when imem_req && imem_valid
- imem_valid  in  1  fetch response valid
- rf_rs1_addr  out  5  equals IR[19:15]; held from the DECODE cycle onward
- rf_rs1_data  in  32  combinational register read data
- rf_we  out  1  write enable; one-cycle pulse in WRITEBACK when rd != 0
- rf_wr_addr  out  5  IR[11:7]
- rf_wr_data  out  32  latched ALU result
- alu_op1 / alu_op2  out  32  latched rs1 value / sign-extended IR[31:20]
- alu_funct3  out  3  IR[14:12]
- alu_funct7  out  7  IR[31:25]
- alu_shamt  out  5  IR[24:20]
- alu_insn_type  out  3  constant 3'b000 (OP-IMM class)
- alu_result  in  32  combinational ALU output
- pc  out  32  current instruction address
- retired  out  1  one-cycle pulse when an instruction completes
- illegal  out  1  high while in TRAP

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, TRAP.
- IDLE → FETCH unconditionally on the next edge. This state exists so that every output is 0 during reset and in the first cycle after it.
- FETCH: imem_req=1, imem_addr=pc. When imem_valid=1, IR ← imem_rdata and go to DECODE; otherwise stay. imem_valid is ignored in every other state.
- DECODE runs the legality check:
  - opcode IR[6:0] must be 7'b0010011.
  - funct3=001 requires funct7=0000000.
  - funct3=101 requires funct7 ∈ {0000000, 0100000}.
  - Any violation → TRAP.
  - If legal: op1 ← rf_rs1_data, op2 ← {{20{IR[31]}},IR[31:20]}, then go to EXECUTE.
- EXECUTE: ALU inputs are stable from latched registers. result ← alu_result, then go to WRITEBACK.
- WRITEBACK:
  - rf_we = (rd != 0).
  - retired=1 even when rd=0.
  - pc ← pc + 4, modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
  - Go to FETCH.
- TRAP: illegal=1, no requests, no writes. pc stays at the faulting instruction. Only reset exits.
- ALU output ports are driven from the IR/op registers in every state. Only the result capture in EXECUTE is architecturally significant.

## Timing
- Reset values: every output is 0 except pc=RESET_PC and imem_addr=RESET_PC. State is IDLE and IR/op1/op2/result are 0.
- Latency per instruction: 1 (FETCH, zero-wait memory) + N wait cycles + DECODE + EXECUTE + WRITEBACK, i.e. 4+N cycles.
- Fetch handshake:
  - imem_req rises on the edge entering FETCH.
  - imem_valid may be high in that same cycle.
  - imem_req falls on the edge after valid is sampled.
  - A single response is consumed per request.
- retired and rf_we are coincident, single-cycle, and registered state decodes.
- Reset asserted mid-operation (any state, including TRAP or during a pending fetch):
  - Immediate return to IDLE, with pending fetch data discarded.
  - rf_we drops without waiting for an edge.

## Structure
- Package opimm_pkg holds:
  - the state_t enum;
  - OPCODE_OP_IMM;
  - F3_ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI_SRAI;
  - F7_ZERO and F7_SRA;
  - INSN_TYPE_OPIMM=3'b000.
- One combinational sub-module, opimm_decode, maps IR to {rs1, rd, funct3, funct7, shamt, imm_sext, legal}. The sequencer itself contains only the FSM and registers.

## Test plan
- Reset, RESET_PC=0, zero-wait memory:
  - Stimulus: ADDI x1,x0,5 (32'h00500093).
  - Required: rf_we with addr 1 and data 5 exactly 4 cycles after the first imem_req; pc becomes 4.
- Memory with 3 wait cycles, rs1=x2=32'hFFFF_FFF0:
  - Stimulus: SRAI x3,x2,2.
  - Required: wr_data 32'hFFFF_FFFC; retired 7 cycles after request rise; imem_req high for exactly 4 cycles.
- Illegal funct7 on SLLI (32'h40109093):
  - Required: illegal=1 and no rf_we; pc unchanged; imem_req stays 0 for 20 further cycles.
- rd=x0 (ADDI x0,x1,1):
  - Required: retired pulses, rf_we stays 0, pc advances by 4.
- RESET_PC=32'hFFFF_FFFC with a legal instruction:
  - Required: pc wraps to 32'h0000_0000 after retire.
- Reset asserted during EXECUTE and during a pending fetch:
  - Required: outputs immediately return to reset values; the next fetch comes from RESET_PC; no stray rf_we.

Source files
------------

// File: rtl/opimm_pkg.sv
// Shared encodings for the OP-IMM sequencer: FSM states, opcode and funct fields,
// and the immediate sign-extension helper.
package opimm_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK,
    S_TRAP
  } state_t;

  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_ADDI      = 3'b000;
  localparam logic [2:0] F3_SLLI      = 3'b001;
  localparam logic [2:0] F3_SLTI      = 3'b010;
  localparam logic [2:0] F3_SLTIU     = 3'b011;
  localparam logic [2:0] F3_XORI      = 3'b100;
  localparam logic [2:0] F3_SRLI_SRAI = 3'b101;
  localparam logic [2:0] F3_ORI       = 3'b110;
  localparam logic [2:0] F3_ANDI      = 3'b111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_SRA  = 7'b0100000;

  localparam logic [2:0] INSN_TYPE_OPIMM = 3'b000;

  function automatic logic [31:0] sext_imm12(input logic [11:0] imm);
    return {{20{imm[11]}}, imm};
  endfunction

endpackage

// File: rtl/opimm_decode.sv
// Combinational field extraction and legality check for a latched OP-IMM word.
module opimm_decode
  import opimm_pkg::*;
(
  input  logic [31:0] ir,
  output logic [4:0]  rs1,
  output logic [4:0]  rd,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [4:0]  shamt,
  output logic [31:0] imm_sext,
  output logic        legal
);

  logic f3_ok;

  assign rs1      = ir[19:15];
  assign rd       = ir[11:7];
  assign funct3   = ir[14:12];
  assign funct7   = ir[31:25];
  assign shamt    = ir[24:20];
  assign imm_sext = sext_imm12(ir[31:20]);

  // Shift encodings reuse the upper immediate bits as funct7, so only those are constrained.
  always_comb begin
    f3_ok = 1'b0;
    case (funct3)
      F3_ADDI, F3_SLTI, F3_SLTIU,
      F3_XORI, F3_ORI, F3_ANDI: f3_ok = 1'b1;
      F3_SLLI:                  f3_ok = (funct7 == F7_ZERO);
      F3_SRLI_SRAI:             f3_ok = (funct7 == F7_ZERO) || (funct7 == F7_SRA);
      default:                  f3_ok = 1'b0;
    endcase
  end

  assign legal = (ir[6:0] == OPCODE_OP_IMM) && f3_ok;

endmodule

// File: rtl/opimm_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback controller for OP-IMM instructions
// driving an external register file and a shared combinational ALU.
module opimm_sequencer
  import opimm_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [4:0]  rf_rs1_addr,
  input  logic [31:0] rf_rs1_data,
  output logic        rf_we,
  output logic [4:0]  rf_wr_addr,
  output logic [31:0] rf_wr_data,
  output logic [31:0] alu_op1,
  output logic [31:0] alu_op2,
  output logic [2:0]  alu_funct3,
  output logic [6:0]  alu_funct7,
  output logic [4:0]  alu_shamt,
  output logic [2:0]  alu_insn_type,
  input  logic [31:0] alu_result,
  output logic [31:0] pc,
  output logic        retired,
  output logic        illegal
);

  state_t      state;
  state_t      state_next;
  logic [31:0] ir;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [31:0] result;

  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rd;
  logic [2:0]  dec_funct3;
  logic [6:0]  dec_funct7;
  logic [4:0]  dec_shamt;
  logic [31:0] dec_imm;
  logic        dec_legal;

  opimm_decode u_decode (
    .ir       (ir),
    .rs1      (dec_rs1),
    .rd       (dec_rd),
    .funct3   (dec_funct3),
    .funct7   (dec_funct7),
    .shamt    (dec_shamt),
    .imm_sext (dec_imm),
    .legal    (dec_legal)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Architectural registers; each is written only in the one state that owns it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir     <= 32'h0;
      op1    <= 32'h0;
      op2    <= 32'h0;
      result <= 32'h0;
      pc     <= RESET_PC;
    end else begin
      case (state)
        S_FETCH:     if (imem_valid) ir <= imem_rdata;
        S_DECODE: begin
          if (dec_legal) begin
            op1 <= rf_rs1_data;
            op2 <= dec_imm;
          end
        end
        S_EXECUTE:   result <= alu_result;
        S_WRITEBACK: pc <= pc + 32'd4;
        default:     ;
      endcase
    end
  end

  // Strobes decode straight from the state register so reset clears them asynchronously.
  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    rf_we      = 1'b0;
    retired    = 1'b0;
    illegal    = 1'b0;
    case (state)
      S_IDLE:      state_next = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_valid) state_next = S_DECODE;
      end
      S_DECODE:    state_next = dec_legal ? S_EXECUTE : S_TRAP;
      S_EXECUTE:   state_next = S_WRITEBACK;
      S_WRITEBACK: begin
        rf_we      = (dec_rd != 5'd0);
        retired    = 1'b1;
        state_next = S_FETCH;
      end
      S_TRAP:      illegal = 1'b1;
      default:     state_next = S_IDLE;
    endcase
  end

  assign imem_addr     = pc;
  assign rf_rs1_addr   = dec_rs1;
  assign rf_wr_addr    = dec_rd;
  assign rf_wr_data    = result;
  assign alu_op1       = op1;
  assign alu_op2       = op2;
  assign alu_funct3    = dec_funct3;
  assign alu_funct7    = dec_funct7;
  assign alu_shamt     = dec_shamt;
  assign alu_insn_type = INSN_TYPE_OPIMM;

endmodule

// File: tb/tb_opimm_sequencer.sv
// Directed bench for opimm_sequencer with a behavioural register file, ALU and
// instruction memory; expected writebacks are queued and retired in order.
module tb_opimm_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        reset_b = 1'b1;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_valid = 1'b0;

  logic        imem_req, rf_we, retired, illegal;
  logic [31:0] imem_addr, rf_rs1_data, rf_wr_data, alu_op1, alu_op2, alu_result, pc;
  logic [4:0]  rf_rs1_addr, rf_wr_addr, alu_shamt;
  logic [2:0]  alu_funct3, alu_insn_type;
  logic [6:0]  alu_funct7;

  logic        imem_req_b, rf_we_b, retired_b, illegal_b;
  logic [31:0] imem_addr_b, rf_rs1_data_b, rf_wr_data_b, alu_op1_b, alu_op2_b, alu_result_b, pc_b;
  logic [4:0]  rf_rs1_addr_b, rf_wr_addr_b, alu_shamt_b;
  logic [2:0]  alu_funct3_b, alu_insn_type_b;
  logic [6:0]  alu_funct7_b;

  logic [31:0] regs [32];

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] pc_next;
  } exp_t;
  exp_t sb[$];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_model(input logic [2:0] f3, input logic [6:0] f7,
                                            input logic [31:0] a, input logic [31:0] b,
                                            input logic [4:0] sh);
    case (f3)
      3'b000:  return a + b;
      3'b010:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b011:  return (a < b) ? 32'd1 : 32'd0;
      3'b100:  return a ^ b;
      3'b110:  return a | b;
      3'b111:  return a & b;
      3'b001:  return a << sh;
      default: return f7[5] ? 32'($signed(a) >>> sh) : (a >> sh);
    endcase
  endfunction

  assign rf_rs1_data   = regs[rf_rs1_addr];
  assign alu_result    = alu_model(alu_funct3, alu_funct7, alu_op1, alu_op2, alu_shamt);
  assign rf_rs1_data_b = regs[rf_rs1_addr_b];
  assign alu_result_b  = alu_model(alu_funct3_b, alu_funct7_b, alu_op1_b, alu_op2_b, alu_shamt_b);

  opimm_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .rf_rs1_addr(rf_rs1_addr), .rf_rs1_data(rf_rs1_data), .rf_we(rf_we),
    .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
    .alu_shamt(alu_shamt), .alu_insn_type(alu_insn_type), .alu_result(alu_result),
    .pc(pc), .retired(retired), .illegal(illegal)
  );

  opimm_sequencer #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
    .clk(clk), .reset(reset_b),
    .imem_req(imem_req_b), .imem_addr(imem_addr_b), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .rf_rs1_addr(rf_rs1_addr_b), .rf_rs1_data(rf_rs1_data_b), .rf_we(rf_we_b),
    .rf_wr_addr(rf_wr_addr_b), .rf_wr_data(rf_wr_data_b),
    .alu_op1(alu_op1_b), .alu_op2(alu_op2_b), .alu_funct3(alu_funct3_b), .alu_funct7(alu_funct7_b),
    .alu_shamt(alu_shamt_b), .alu_insn_type(alu_insn_type_b), .alu_result(alu_result_b),
    .pc(pc_b), .retired(retired_b), .illegal(illegal_b)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic report_timeout(input string tag);
    vectors++;
    miscompares++;
    $error("FAIL %s: observed timeout expected DUT event", tag);
  endtask

  task automatic wait_req(output logic got);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      if (imem_req) got = 1'b1;
      else tick();
    end
  endtask

  task automatic run_insn(input string tag, input logic [31:0] insn, input int waits,
                          input logic we, input logic [4:0] addr, input logic [31:0] data,
                          input logic [31:0] pc_next);
    logic got;
    logic done;
    int   lat;
    int   req_cycles;
    int   we_seen;
    exp_t e;
    sb.push_back('{we, addr, data, pc_next});
    wait_req(got);
    if (!got) begin
      report_timeout({tag, " req"});
      void'(sb.pop_back());
      return;
    end
    done = 1'b0; lat = 0; req_cycles = 0; we_seen = 0;
    while (!done && lat < 40) begin
      lat++;
      if (imem_req) begin
        req_cycles++;
        imem_rdata = insn;
        imem_valid = (req_cycles > waits);
      end else begin
        imem_valid = 1'b0;
      end
      if (rf_we) we_seen++;
      if (retired) begin
        done = 1'b1;
        e = sb.pop_front();
        check({tag, " latency"}, 32'(lat), 32'(4 + waits));
        check({tag, " req_cycles"}, 32'(req_cycles), 32'(waits + 1));
        check({tag, " rf_we"}, {31'b0, rf_we}, {31'b0, e.we});
        if (e.we) begin
          check({tag, " wr_addr"}, {27'b0, rf_wr_addr}, {27'b0, e.addr});
          check({tag, " wr_data"}, rf_wr_data, e.data);
          regs[rf_wr_addr] = rf_wr_data;
        end
      end
      tick();
    end
    if (!done) begin
      report_timeout({tag, " retire"});
      void'(sb.pop_front());
    end else begin
      check({tag, " we_pulses"}, 32'(we_seen), e.we ? 32'd1 : 32'd0);
      check({tag, " pc"}, pc, e.pc_next);
      check({tag, " imem_addr"}, imem_addr, e.pc_next);
    end
  endtask

  initial begin
    logic got;
    int   req_cnt;
    int   we_cnt;
    int   ill_lo;
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    regs[2] = 32'hFFFF_FFF0;

    // Reset state
    tick(); tick();
    check("rst imem_req", {31'b0, imem_req}, 32'h0);
    check("rst imem_addr", imem_addr, 32'h0);
    check("rst pc", pc, 32'h0);
    check("rst rf_we", {31'b0, rf_we}, 32'h0);
    check("rst retired", {31'b0, retired}, 32'h0);
    check("rst illegal", {31'b0, illegal}, 32'h0);
    check("rst alu_op1", alu_op1, 32'h0);
    check("rst alu_op2", alu_op2, 32'h0);
    check("rst wr_data", rf_wr_data, 32'h0);
    check("insn_type", {29'b0, alu_insn_type}, 32'h0);
    check("rst_b pc", pc_b, 32'hFFFF_FFFC);
    check("rst_b imem_addr", imem_addr_b, 32'hFFFF_FFFC);

    reset = 1'b0;
    check("idle imem_req", {31'b0, imem_req}, 32'h0);

    run_insn("addi_x1", 32'h0050_0093, 0, 1'b1, 5'd1, 32'h0000_0005, 32'h0000_0004);
    run_insn("srai_x3", 32'h4021_5193, 3, 1'b1, 5'd3, 32'hFFFF_FFFC, 32'h0000_0008);
    run_insn("xori_x4", 32'hFFF0_C213, 1, 1'b1, 5'd4, 32'hFFFF_FFFA, 32'h0000_000C);
    run_insn("slti_x5", 32'h0011_2293, 0, 1'b1, 5'd5, 32'h0000_0001, 32'h0000_0010);
    run_insn("addi_x0", 32'h0010_8013, 2, 1'b0, 5'd0, 32'h0, 32'h0000_0014);

    // Illegal SLLI funct7: trap and stay there with memory still responding
    wait_req(got);
    if (!got) report_timeout("trap req");
    imem_rdata = 32'h4010_9093;
    imem_valid = 1'b1;
    tick();
    imem_valid = 1'b0;
    tick();
    check("trap illegal", {31'b0, illegal}, 32'h1);
    check("trap pc", pc, 32'h0000_0014);
    check("trap rf_we", {31'b0, rf_we}, 32'h0);
    req_cnt = 0; we_cnt = 0; ill_lo = 0;
    imem_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (imem_req) req_cnt++;
      if (rf_we || retired) we_cnt++;
      if (!illegal) ill_lo++;
    end
    imem_valid = 1'b0;
    check("trap req_cycles", 32'(req_cnt), 32'h0);
    check("trap writes", 32'(we_cnt), 32'h0);
    check("trap illegal_lo", 32'(ill_lo), 32'h0);
    check("trap pc_hold", pc, 32'h0000_0014);

    // Reset out of TRAP
    reset = 1'b1;
    #1;
    check("trap_rst illegal", {31'b0, illegal}, 32'h0);
    check("trap_rst pc", pc, 32'h0);
    tick();
    reset = 1'b0;
    check("trap_rst idle req", {31'b0, imem_req}, 32'h0);

    // Reset during EXECUTE
    wait_req(got);
    if (!got) report_timeout("exec req");
    check("exec fetch addr", imem_addr, 32'h0);
    imem_rdata = 32'h0070_0313;
    imem_valid = 1'b1;
    tick();
    imem_valid = 1'b0;
    tick();
    check("exec op2", alu_op2, 32'h0000_0007);
    reset = 1'b1;
    #1;
    check("exec_rst op2", alu_op2, 32'h0);
    check("exec_rst wr_addr", {27'b0, rf_wr_addr}, 32'h0);
    check("exec_rst req", {31'b0, imem_req}, 32'h0);
    tick();
    reset = 1'b0;

    // Reset during WRITEBACK drops rf_we without an edge
    wait_req(got);
    if (!got) report_timeout("wb req");
    imem_rdata = 32'h0070_0313;
    imem_valid = 1'b1;
    tick();
    imem_valid = 1'b0;
    tick(); tick();
    check("wb rf_we", {31'b0, rf_we}, 32'h1);
    check("wb wr_data", rf_wr_data, 32'h0000_0007);
    reset = 1'b1;
    #1;
    check("wb_rst rf_we", {31'b0, rf_we}, 32'h0);
    check("wb_rst retired", {31'b0, retired}, 32'h0);
    check("wb_rst pc", pc, 32'h0);
    tick();
    reset = 1'b0;

    // Reset during a pending fetch; the late response must be discarded
    wait_req(got);
    if (!got) report_timeout("pend req");
    imem_rdata = 32'h0090_0393;
    imem_valid = 1'b0;
    tick(); tick();
    check("pend req_hi", {31'b0, imem_req}, 32'h1);
    reset = 1'b1;
    #1;
    check("pend_rst req", {31'b0, imem_req}, 32'h0);
    imem_valid = 1'b1;
    tick();
    imem_valid = 1'b0;
    reset = 1'b0;
    check("pend idle wr_addr", {27'b0, rf_wr_addr}, 32'h0);
    tick();
    check("pend refetch addr", imem_addr, 32'h0);
    run_insn("sltiu_x8", 32'h0011_3413, 0, 1'b1, 5'd8, 32'h0, 32'h0000_0004);

    // PC wrap on the second instance
    reset = 1'b1;
    reset_b = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      if (imem_req_b) got = 1'b1;
      else tick();
    end
    if (!got) report_timeout("wrap req");
    check("wrap fetch addr", imem_addr_b, 32'hFFFF_FFFC);
    imem_rdata = 32'h0050_0093;
    imem_valid = 1'b1;
    tick();
    imem_valid = 1'b0;
    tick(); tick();
    check("wrap retired", {31'b0, retired_b}, 32'h1);
    check("wrap wr_data", rf_wr_data_b, 32'h0000_0005);
    tick();
    check("wrap pc", pc_b, 32'h0);
    check("wrap imem_addr", imem_addr_b, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
